// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch controller feeding a UART transmitter with a multi-cycle TxEn pulse.
// Define UART_TX_FEED_GAP_EN to add an inter-frame gap counted in Tick pulses.
module uart_tx_feeder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned EN_HOLD = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        WrEn,
  input  logic [7:0]  WrData,
  output logic        Full,
  output logic        Empty,
  output logic [AW:0] Level,
  output logic        Overflow,
  output logic [7:0]  TxData,
  output logic        TxEn,
  input  logic        TxDone,
  input  logic        Tick,
  input  logic [7:0]  GapTicks,
  output logic        Busy
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(EN_HOLD);

`ifdef UART_TX_FEED_GAP_EN
  typedef enum logic [2:0] {IDLE, ASSERT, WAIT_DONE, WAIT_CLR, GAP} state_e;
  logic [7:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_DONE, WAIT_CLR} state_e;
  // Gap inputs stay on the port list but have no function in this build.
  logic gap_unused;
  assign gap_unused = ^{Tick, GapTicks};
`endif

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          push, pop;

  // Launch sequencing; pop only when idle and the transmitter shows no stale completion.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    hold_d    = hold_q;
    pop       = 1'b0;
`ifdef UART_TX_FEED_GAP_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_q && !TxDone) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + AW'(1);
          tx_en_d   = 1'b1;
          hold_d    = HW'(EN_HOLD - 1);
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        if (hold_q == '0) begin
          tx_en_d = 1'b0;
          state_d = WAIT_DONE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      WAIT_DONE: begin
        if (TxDone) state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!TxDone) begin
`ifdef UART_TX_FEED_GAP_EN
          state_d = GAP;
          gap_d   = GapTicks;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_FEED_GAP_EN
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else if (Tick) begin
          gap_d = gap_q - 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a push is judged against the pre-edge Full, so a same-edge pop cannot rescue it.
  always_comb begin
    push     = WrEn && !full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    full_d   = (level_d == LW'(DEPTH));
    empty_d  = (level_d == '0);
    ovf_d    = ovf_q | (WrEn & full_q);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= '0;
`ifdef UART_TX_FEED_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
`ifdef UART_TX_FEED_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= WrData;
  end

  assign Full     = full_q;
  assign Empty    = empty_q;
  assign Level    = level_q;
  assign Overflow = ovf_q;
  assign TxData   = tx_data_q;
  assign TxEn     = tx_en_q;
  assign Busy     = busy_q;

endmodule
